// File: rtl/tmds_decoder.sv
// TMDS receive decoder: aligns on control tokens (bit-slip), then decodes 10b->8b.
// Define TMDS_DECODER_STATS_EN to add slip/lock-loss statistics outputs.
module tmds_decoder #(
  parameter int LOCK_RUN    = 8,
  parameter int SEARCH_LEN  = 2048,
  parameter int SLIP_SETTLE = 8
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic [9:0] i_rx_word,
  output logic [7:0] o_data,
  output logic       o_de,
  output logic       o_hs,
  output logic       o_vs,
  output logic       o_locked,
  output logic       o_bitslip
`ifdef TMDS_DECODER_STATS_EN
  ,
  output logic [7:0] o_slip_count,
  output logic [7:0] o_loss_count
`endif
);

  localparam int RW = $clog2(LOCK_RUN + 1);
  localparam int TW = $clog2(SEARCH_LEN + 1);

  localparam logic [RW-1:0] RUN_LAST  = RW'(LOCK_RUN - 1);
  localparam logic [TW-1:0] SRCH_LAST = TW'(SEARCH_LEN - 1);
  localparam logic [TW-1:0] SETL_LAST = TW'(SLIP_SETTLE - 1);
  localparam logic [TW-1:0] TMR_MAX   = '1;

  localparam logic [9:0] TOK0 = 10'b1101010100;
  localparam logic [9:0] TOK1 = 10'b0010101011;
  localparam logic [9:0] TOK2 = 10'b0101010100;
  localparam logic [9:0] TOK3 = 10'b1010101011;

  typedef enum logic [1:0] {
    SEARCH,
    SLIP,
    SETTLE,
    LOCKED
  } state_t;

  state_t        state, state_n;
  logic [RW-1:0] run, run_n;
  logic [TW-1:0] tmr, tmr_n, tmr_inc;
  logic          is_ctrl;
  logic [1:0]    ctrl;
  logic [7:0]    d, dec;

  always_comb begin
    is_ctrl = 1'b1;
    ctrl    = 2'b00;
    unique case (1'b1)
      (i_rx_word == TOK0): ctrl = 2'b00;
      (i_rx_word == TOK1): ctrl = 2'b01;
      (i_rx_word == TOK2): ctrl = 2'b10;
      (i_rx_word == TOK3): ctrl = 2'b11;
      default:             is_ctrl = 1'b0;
    endcase
  end

  always_comb begin
    d      = i_rx_word[9] ? ~i_rx_word[7:0] : i_rx_word[7:0];
    dec    = '0;
    dec[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      dec[i] = i_rx_word[8] ? (d[i] ^ d[i-1])
                            : ~(d[i] ^ d[i-1]);
    end
  end

  assign tmr_inc = (tmr == TMR_MAX) ? tmr : tmr + TW'(1);

  always_comb begin
    state_n = state;
    run_n   = run;
    tmr_n   = tmr;
    unique case (state)
      SEARCH: begin
        run_n = is_ctrl ? run + RW'(1) : '0;
        tmr_n = tmr_inc;
        if (is_ctrl && run == RUN_LAST) begin
          state_n = LOCKED;
          run_n   = '0;
          tmr_n   = '0;
        end else if (tmr == SRCH_LAST) begin
          state_n = SLIP;
          run_n   = '0;
          tmr_n   = '0;
        end
      end
      SLIP: begin
        state_n = SETTLE;
        tmr_n   = '0;
      end
      SETTLE: begin
        tmr_n = tmr_inc;
        if (tmr == SETL_LAST) begin
          state_n = SEARCH;
          run_n   = '0;
          tmr_n   = '0;
        end
      end
      LOCKED: begin
        tmr_n = is_ctrl ? '0 : tmr_inc;
        // leave on the word that brings the quiet count to SEARCH_LEN
        if (!is_ctrl && tmr == SRCH_LAST) begin
          state_n = SEARCH;
          run_n   = '0;
          tmr_n   = '0;
        end
      end
      default: state_n = SEARCH;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state  <= SEARCH;
      run    <= '0;
      tmr    <= '0;
      o_data <= '0;
      o_de   <= 1'b0;
      o_hs   <= 1'b0;
      o_vs   <= 1'b0;
    end else begin
      state <= state_n;
      run   <= run_n;
      tmr   <= tmr_n;
      if (state == LOCKED && !is_ctrl) begin
        o_de   <= 1'b1;
        o_data <= dec;
      end else begin
        o_de   <= 1'b0;
        o_data <= '0;
      end
      if (state == LOCKED && is_ctrl) begin
        o_hs <= ctrl[0];
        o_vs <= ctrl[1];
      end
    end
  end

  assign o_locked  = (state == LOCKED);
  assign o_bitslip = (state == SLIP);

`ifdef TMDS_DECODER_STATS_EN
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_slip_count <= '0;
      o_loss_count <= '0;
    end else begin
      if (state == SLIP && o_slip_count != 8'hFF)
        o_slip_count <= o_slip_count + 8'd1;
      if (state == LOCKED && state_n == SEARCH
          && o_loss_count != 8'hFF)
        o_loss_count <= o_loss_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tmds_decoder.sv
// Bench for tmds_decoder: random stimulus against a behavioural model,
// plus directed lock, decode, slip and reset scenarios.
module tb_tmds_decoder;

  localparam int LOCK_RUN    = 8;
  localparam int SEARCH_LEN  = 2048;
  localparam int SLIP_SETTLE = 8;

  logic       i_clk = 1'b0;
  logic       i_rstn = 1'b1;
  logic [9:0] i_rx_word = '0;
  logic [7:0] o_data;
  logic       o_de, o_hs, o_vs, o_locked, o_bitslip;
`ifdef TMDS_DECODER_STATS_EN
  logic [7:0] o_slip_count, o_loss_count;
`endif

  tmds_decoder #(
    .LOCK_RUN   (LOCK_RUN),
    .SEARCH_LEN (SEARCH_LEN),
    .SLIP_SETTLE(SLIP_SETTLE)
  ) dut (
    .i_clk       (i_clk),
    .i_rstn      (i_rstn),
    .i_rx_word   (i_rx_word),
    .o_data      (o_data),
    .o_de        (o_de),
    .o_hs        (o_hs),
    .o_vs        (o_vs),
    .o_locked    (o_locked),
    .o_bitslip   (o_bitslip)
`ifdef TMDS_DECODER_STATS_EN
    ,
    .o_slip_count(o_slip_count),
    .o_loss_count(o_loss_count)
`endif
  );

  always #5 i_clk = ~i_clk;

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  logic [9:0] tok [4] = '{10'b1101010100, 10'b0010101011,
                          10'b0101010100, 10'b1010101011};

  // model state: plain counters of what has happened on the link
  bit   m_locked, m_slip;
  int   m_run, m_hunt, m_quiet, m_settle, m_slips, m_loss;
  logic [7:0] e_data;
  bit   e_de, e_hs, e_vs;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic int tok_idx(logic [9:0] w);
    for (int k = 0; k < 4; k++)
      if (tok[k] == w) return k;
    return -1;
  endfunction

  // invert the encoder by search: find the byte whose stage-1 code matches
  function automatic logic [7:0] decode(logic [9:0] w);
    logic [7:0] q, b, e;
    q = w[9] ? ~w[7:0] : w[7:0];
    for (int v = 0; v < 256; v++) begin
      b    = 8'(v);
      e[0] = b[0];
      for (int i = 1; i < 8; i++)
        e[i] = w[8] ? (e[i-1] ^ b[i]) : ~(e[i-1] ^ b[i]);
      if (e == q) return b;
    end
    return 8'h00;
  endfunction

  task automatic model_reset();
    m_locked = 0; m_slip = 0;
    m_run = 0; m_hunt = 0; m_quiet = 0; m_settle = 0;
    m_slips = 0; m_loss = 0;
    e_data = '0; e_de = 0; e_hs = 0; e_vs = 0;
  endtask

  task automatic model_step(logic [9:0] w);
    int t;
    t = tok_idx(w);
    if (m_locked) begin
      if (t >= 0) begin
        e_de = 0; e_data = '0;
        e_hs = t[0]; e_vs = t[1];
        m_quiet = 0;
      end else begin
        e_de = 1; e_data = decode(w);
        m_quiet++;
        if (m_quiet == SEARCH_LEN) begin
          m_locked = 0; m_run = 0; m_hunt = 0;
          if (m_loss < 255) m_loss++;
        end
      end
    end else begin
      e_de = 0; e_data = '0;
      if (m_settle > 0) begin
        m_settle--;
        if (m_settle == 0) begin m_run = 0; m_hunt = 0; end
      end else if (m_slip) begin
        m_slip = 0;
        m_settle = SLIP_SETTLE;
        if (m_slips < 255) m_slips++;
      end else begin
        m_run = (t >= 0) ? m_run + 1 : 0;
        m_hunt++;
        if (m_run == LOCK_RUN) begin
          m_locked = 1; m_quiet = 0;
        end else if (m_hunt == SEARCH_LEN) begin
          m_slip = 1;
        end
      end
    end
  endtask

  task automatic cycle(input logic [9:0] w);
    i_rx_word = w;
    @(posedge i_clk);
    model_step(w);
    @(negedge i_clk);
  endtask

  // called at a negedge; returns with reset released before the next posedge
  task automatic do_reset(input int n);
    #2 i_rstn = 1'b0;
    model_reset();
    cmp_en = 1'b1;
    #1;
    chk("rst_bitslip", o_bitslip, 0);
    chk("rst_locked", o_locked, 0);
`ifdef TMDS_DECODER_STATS_EN
    chk("rst_slip_count", o_slip_count, 0);
    chk("rst_loss_count", o_loss_count, 0);
`endif
    repeat (n) begin
      i_rx_word = 10'($urandom);
      @(negedge i_clk);
    end
    #2 i_rstn = 1'b1;
  endtask

  initial begin
    forever begin
      @(negedge i_clk);
      if (cmp_en) begin
        chk("data", o_data, e_data);
        chk("de", o_de, e_de);
        chk("hs", o_hs, e_hs);
        chk("vs", o_vs, e_vs);
        chk("locked", o_locked, m_locked);
        chk("bitslip", o_bitslip, m_slip);
`ifdef TMDS_DECODER_STATS_EN
        chk("slip_count", o_slip_count, m_slips);
        chk("loss_count", o_loss_count, m_loss);
`endif
      end
    end
  end

  initial begin
    int n, nt, nd;
    chk("model_dec_100", decode(10'h100), 8'h00);
    chk("model_dec_200", decode(10'h200), 8'hFF);
    chk("model_tok_2ab", tok_idx(10'h2AB), 3);
    chk("model_tok_354", tok_idx(10'h354), 0);

    @(negedge i_clk);
    do_reset(5);
    repeat (LOCK_RUN) begin
      cycle(10'($urandom));
      chk("no_lock_after_rst", o_locked, 0);
    end

    repeat (LOCK_RUN - 1) cycle(10'h354);
    cycle(10'h100);
    chk("no_lock_run7", o_locked, 0);
    for (int i = 0; i < LOCK_RUN; i++) begin
      cycle(10'h354);
      chk("lock_run8", o_locked, (i == LOCK_RUN - 1));
    end

    cycle(10'h100);
    chk("dec100_data", o_data, 8'h00);
    chk("dec100_de", o_de, 1);
    cycle(10'h200);
    chk("dec200_data", o_data, 8'hFF);
    chk("dec200_de", o_de, 1);
    cycle(10'h2AB);
    chk("tok11_de", o_de, 0);
    chk("tok11_hs", o_hs, 1);
    chk("tok11_vs", o_vs, 1);
    chk("tok11_data", o_data, 0);

    repeat (SEARCH_LEN - 1) cycle(10'h100);
    chk("still_locked", o_locked, 1);
    cycle(10'h100);
    chk("lock_lost", o_locked, 0);
    cycle(10'h100);
    chk("de_forced_0", o_de, 0);
    for (int i = 0; i < LOCK_RUN; i++) begin
      cycle(tok[i % 4]);
      chk("relock", o_locked, (i == LOCK_RUN - 1));
    end
`ifdef TMDS_DECODER_STATS_EN
    chk("loss_count_1", o_loss_count, 1);
`endif

    do_reset(3);
    n = 0;
    do begin cycle(10'h155); n++; end
    while (!o_bitslip && n < 3000);
    chk("first_slip_at", n, SEARCH_LEN);
    n = 0;
    do begin cycle(10'h155); n++; end
    while (!o_bitslip && n < 3000);
    chk("slip_period", n, 1 + SLIP_SETTLE + SEARCH_LEN);
    chk("slip_high", o_bitslip, 1);
    do_reset(3);

    for (int s = 0; s < 40; s++) begin
      nt = $urandom_range(0, 12);
      nd = ($urandom_range(0, 7) == 0) ? 2100 : $urandom_range(0, 150);
      repeat (nt) cycle(tok[$urandom_range(0, 3)]);
      repeat (nd) cycle(10'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
